// File: rtl/ad_wave_rec.sv
// ad_wave_rec: capture front end for an 8-bit parallel ADC.
// The incoming sample stream is decimated. A host request arms the block, which
// then waits for a level crossing or a timeout and writes one full buffer of
// consecutive samples into an external simple-dual-port RAM.
module ad_wave_rec #(
    parameter logic [7:0]  DIV          = 8'd5,
    parameter int          ADDR_W       = 8,
    parameter logic [15:0] TRIG_TIMEOUT = 16'd50000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ad_clk,
    input  logic [7:0]        ad_data,
    input  logic              cap_start,
    input  logic [7:0]        trig_level,
    input  logic              trig_edge,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              cap_busy,
    output logic              cap_done,
    output logic              trig_forced
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
    localparam logic [15:0]       TCNT_LAST = TRIG_TIMEOUT - 16'd1;
    localparam logic [15:0]       TCNT_MAX  = 16'hFFFF;

    state_t            state;
    state_t            state_nx;
    logic [7:0]        ad_q;
    logic [7:0]        prev;
    logic              prev_valid;
    logic [7:0]        lvl;
    logic              edge_fall;
    logic [7:0]        div_cnt;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       tcnt;

    logic [7:0]        cur;
    logic              strobe;
    logic              rise_x;
    logic              fall_x;
    logic              crossing;
    logic              arm;
    logic              wr_go;
    logic [ADDR_W-1:0] wr_addr_nx;
    logic              force_set;
    logic              tcnt_inc;

    // The ADC samples on the opposite phase, so it gets the inverted clock.
    assign ad_clk = ~clk;

    // Strobe and trigger detection. The trigger compares the current decimated
    // sample against the previous one. A crossing needs a valid previous sample.
    always_comb begin
        cur      = ad_q;
        strobe   = (div_cnt == DIV) && ((state == ARM) || (state == CAPTURE));
        rise_x   = prev_valid && (prev < lvl) && (cur >= lvl);
        fall_x   = prev_valid && (prev > lvl) && (cur <= lvl);
        crossing = edge_fall ? fall_x : rise_x;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and per-strobe write/trigger decisions.
    always_comb begin
        state_nx   = state;
        arm        = 1'b0;
        wr_go      = 1'b0;
        wr_addr_nx = addr;
        force_set  = 1'b0;
        tcnt_inc   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (cap_start) begin
                    state_nx = ARM;
                    arm      = 1'b1;
                end else begin
                    state_nx = state;
                end
            end
            ARM: begin
                if (strobe) begin
                    if (crossing) begin
                        // A real crossing wins over a timeout on the same strobe.
                        wr_go      = 1'b1;
                        wr_addr_nx = ADDR_ZERO;
                        state_nx   = CAPTURE;
                    end else if (tcnt == TCNT_LAST) begin
                        wr_go      = 1'b1;
                        wr_addr_nx = ADDR_ZERO;
                        force_set  = 1'b1;
                        state_nx   = CAPTURE;
                    end else begin
                        tcnt_inc = 1'b1;
                        state_nx = ARM;
                    end
                end else begin
                    state_nx = ARM;
                end
            end
            CAPTURE: begin
                if (strobe) begin
                    wr_go      = 1'b1;
                    wr_addr_nx = addr + ADDR_ONE;
                    if (wr_addr_nx == ADDR_LAST) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = CAPTURE;
                    end
                end else begin
                    state_nx = CAPTURE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Input register and decimation counter. An accepted arm realigns the
    // decimation phase so the first strobe comes DIV+1 clocks later.
    always_ff @(posedge clk) begin
        if (rst) begin
            ad_q    <= 8'd0;
            div_cnt <= 8'd0;
        end else begin
            ad_q <= ad_data;
            if (arm) begin
                div_cnt <= 8'd0;
            end else if (div_cnt >= DIV) begin
                div_cnt <= 8'd0;
            end else begin
                div_cnt <= div_cnt + 8'd1;
            end
        end
    end

    // Capture context: trigger settings, previous sample, timeout and address.
    always_ff @(posedge clk) begin
        if (rst) begin
            lvl         <= 8'd0;
            edge_fall   <= 1'b0;
            prev        <= 8'd0;
            prev_valid  <= 1'b0;
            tcnt        <= 16'd0;
            addr        <= ADDR_ZERO;
            trig_forced <= 1'b0;
        end else if (arm) begin
            lvl         <= trig_level;
            edge_fall   <= trig_edge;
            prev_valid  <= 1'b0;
            tcnt        <= 16'd0;
            addr        <= ADDR_ZERO;
            trig_forced <= 1'b0;
        end else begin
            if (strobe) begin
                prev       <= cur;
                prev_valid <= 1'b1;
            end
            // The timeout counter saturates rather than wrapping.
            if (tcnt_inc && (tcnt != TCNT_MAX)) begin
                tcnt <= tcnt + 16'd1;
            end
            if (wr_go) begin
                addr <= wr_addr_nx;
            end
            if (force_set) begin
                trig_forced <= 1'b1;
            end
        end
    end

    // RAM write port and status outputs, all registered one clock after the strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en    <= 1'b0;
            wr_addr  <= ADDR_ZERO;
            wr_data  <= 8'd0;
            cap_busy <= 1'b0;
            cap_done <= 1'b0;
        end else begin
            wr_en <= wr_go;
            if (wr_go) begin
                wr_addr <= wr_addr_nx;
                wr_data <= cur;
            end
            cap_busy <= (state_nx == ARM) || (state_nx == CAPTURE);
            cap_done <= (state_nx == DONE);
        end
    end

endmodule

// File: tb/tb_ad_wave_rec.sv
// Directed self-checking bench for ad_wave_rec.
// dut0 runs undecimated with a long timeout, and dut5 runs with DIV=5 and a
// timeout of 4 strobes. Writes from each DUT are logged on the falling edge
// and checked against hand-computed expectations.
module tb_ad_wave_rec;

    logic       clk;
    logic       rst;
    int         cyc;
    int         n_chk;
    int         n_pass;

    // dut0 signals
    logic       ad_clk0;
    logic [7:0] ad0;
    logic       cap_start0;
    logic [7:0] lvl0;
    logic       edge0;
    logic       wr_en0;
    logic [7:0] wr_addr0;
    logic [7:0] wr_data0;
    logic       cap_busy0;
    logic       cap_done0;
    logic       forced0;

    // dut5 signals
    logic       ad_clk5;
    logic [7:0] ad5;
    logic       cap_start5;
    logic [7:0] lvl5;
    logic       edge5;
    logic       wr_en5;
    logic [7:0] wr_addr5;
    logic [7:0] wr_data5;
    logic       cap_busy5;
    logic       cap_done5;
    logic       forced5;

    // write logs
    int         n0;
    logic [7:0] wa0  [0:2047];
    logic [7:0] wd0  [0:2047];
    logic [7:0] wad0 [0:2047];
    logic       wdn0 [0:2047];
    int         n5;
    logic [7:0] wa5  [0:511];
    logic [7:0] wd5  [0:511];
    int         wc5  [0:511];
    logic       wdn5 [0:511];

    ad_wave_rec #(.DIV(8'd0), .ADDR_W(8), .TRIG_TIMEOUT(16'd50000)) dut0 (
        .clk(clk), .rst(rst), .ad_clk(ad_clk0), .ad_data(ad0),
        .cap_start(cap_start0), .trig_level(lvl0), .trig_edge(edge0),
        .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
        .cap_busy(cap_busy0), .cap_done(cap_done0), .trig_forced(forced0)
    );

    ad_wave_rec #(.DIV(8'd5), .ADDR_W(8), .TRIG_TIMEOUT(16'd4)) dut5 (
        .clk(clk), .rst(rst), .ad_clk(ad_clk5), .ad_data(ad5),
        .cap_start(cap_start5), .trig_level(lvl5), .trig_edge(edge5),
        .wr_en(wr_en5), .wr_addr(wr_addr5), .wr_data(wr_data5),
        .cap_busy(cap_busy5), .cap_done(cap_done5), .trig_forced(forced5)
    );

    // clock generation
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // cycle counter
    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // write logger for dut0
    always @(negedge clk) begin
        if (wr_en0 && (n0 < 2048)) begin
            wa0[n0]  <= wr_addr0;
            wd0[n0]  <= wr_data0;
            wad0[n0] <= ad0;
            wdn0[n0] <= cap_done0;
            n0       <= n0 + 1;
        end
    end

    // write logger for dut5
    always @(negedge clk) begin
        if (wr_en5 && (n5 < 512)) begin
            wa5[n5]  <= wr_addr5;
            wd5[n5]  <= wr_data5;
            wc5[n5]  <= cyc;
            wdn5[n5] <= cap_done5;
            n5       <= n5 + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Run dut0 until cap_done, optionally ramping ad0 and pulsing cap_start once.
    task automatic wait_done0(input bit ramp, input int pulse_at);
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            cap_start0 = (i == pulse_at);
            if (ramp) begin
                ad0 = ad0 + 8'd1;
            end
            if (cap_done0) begin
                break;
            end
        end
        cap_start0 = 1'b0;
        check_val("done0_reached", 32'(cap_done0), 32'd1);
        @(negedge clk);
        #1;
    endtask

    // Verify one dut0 capture: 256 in-order writes, data d0 + k*inc, flags.
    task automatic verify_cap0(input string tag, input int base, input logic [7:0] d0,
                               input logic [7:0] inc, input logic forced_exp);
        int bad_a;
        int bad_d;
        logic [7:0] e;
        bad_a = 0;
        bad_d = 0;
        e     = d0;
        check_val({tag, "_count"}, 32'(n0 - base), 32'd256);
        for (int k = 0; k < 256; k++) begin
            if ((base + k) < 2048) begin
                if (wa0[base + k] !== 8'(k)) begin
                    bad_a = bad_a + 1;
                end
                if (wd0[base + k] !== e) begin
                    bad_d = bad_d + 1;
                end
            end
            e = e + inc;
        end
        check_val({tag, "_first_data"}, 32'(wd0[base]), 32'(d0));
        check_val({tag, "_addr_seq_errs"}, 32'(bad_a), 32'd0);
        check_val({tag, "_data_errs"}, 32'(bad_d), 32'd0);
        check_val({tag, "_done_at_last"}, 32'(wdn0[base + 255]), 32'd1);
        check_val({tag, "_done_before_last"}, 32'(wdn0[base + 254]), 32'd0);
        check_val({tag, "_forced"}, 32'(forced0), 32'(forced_exp));
        check_val({tag, "_done_level"}, 32'(cap_done0), 32'd1);
        check_val({tag, "_busy_low"}, 32'(cap_busy0), 32'd0);
    endtask

    initial begin
        int base;
        int snap;
        int k0;
        int bad_a;
        int bad_d;
        int bad_s;
        cyc        = 0;
        n_chk      = 0;
        n_pass     = 0;
        n0         = 0;
        n5         = 0;
        rst        = 1'b1;
        ad0        = 8'd0;
        cap_start0 = 1'b0;
        lvl0       = 8'd0;
        edge0      = 1'b0;
        ad5        = 8'd0;
        cap_start5 = 1'b0;
        lvl5       = 8'd0;
        edge5      = 1'b0;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_wr_en", 32'(wr_en0), 32'd0);
        check_val("rst_wr_addr", 32'(wr_addr0), 32'd0);
        check_val("rst_wr_data", 32'(wr_data0), 32'd0);
        check_val("rst_busy", 32'(cap_busy0), 32'd0);
        check_val("rst_done", 32'(cap_done0), 32'd0);
        check_val("rst_forced", 32'(forced0), 32'd0);
        check_val("rst_busy5", 32'(cap_busy5), 32'd0);
        check_val("ad_clk_low_phase", 32'(ad_clk0), 32'd1);
        @(posedge clk);
        #1;
        check_val("ad_clk_high_phase", 32'(ad_clk0), 32'd0);
        rst = 1'b0;

        // ---- test 1: ramp, rising trigger at 0x80 ----
        @(posedge clk);
        #1;
        base       = n0;
        ad0        = 8'd0;
        lvl0       = 8'h80;
        edge0      = 1'b0;
        cap_start0 = 1'b1;
        wait_done0(1'b1, -1);
        verify_cap0("ramp", base, 8'h80, 8'd1, 1'b0);
        check_val("ramp_latency", 32'(wad0[base] - wd0[base]), 32'd2);

        // ---- test 2: re-arm from DONE, falling edge, rising step ignored ----
        @(posedge clk);
        #1;
        check_val("rearm_done_before", 32'(cap_done0), 32'd1);
        base       = n0;
        ad0        = 8'h30;
        lvl0       = 8'h40;
        edge0      = 1'b1;
        cap_start0 = 1'b1;
        @(posedge clk);
        #1;
        cap_start0 = 1'b0;
        check_val("rearm_done_cleared", 32'(cap_done0), 32'd0);
        check_val("rearm_busy", 32'(cap_busy0), 32'd1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        ad0 = 8'h90;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check_val("fall_no_rise_trig", 32'(n0 - base), 32'd0);
        ad0 = 8'h30;
        wait_done0(1'b0, -1);
        verify_cap0("fall", base, 8'h30, 8'd0, 1'b0);

        // ---- test 3: first strobe 0xFF no trigger; cap_start during CAPTURE ----
        @(posedge clk);
        #1;
        base       = n0;
        ad0        = 8'hFF;
        lvl0       = 8'h80;
        edge0      = 1'b0;
        cap_start0 = 1'b1;
        @(posedge clk);
        #1;
        cap_start0 = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check_val("ff_no_trig", 32'(n0 - base), 32'd0);
        check_val("ff_busy", 32'(cap_busy0), 32'd1);
        ad0 = 8'h00;
        @(posedge clk);
        #1;
        ad0 = 8'h80;
        wait_done0(1'b1, 50);
        verify_cap0("ignore_start", base, 8'h80, 8'd1, 1'b0);

        // ---- test 4: reset at write 100, then restart ----
        @(posedge clk);
        #1;
        base       = n0;
        ad0        = 8'd0;
        lvl0       = 8'h80;
        edge0      = 1'b0;
        cap_start0 = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            cap_start0 = 1'b0;
            ad0        = ad0 + 8'd1;
            if ((n0 - base) >= 100) begin
                break;
            end
        end
        check_val("rst_mid_reached", 32'(n0 - base), 32'd100);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_mid_wr_en", 32'(wr_en0), 32'd0);
        check_val("rst_mid_busy", 32'(cap_busy0), 32'd0);
        check_val("rst_mid_done", 32'(cap_done0), 32'd0);
        #1;
        snap = n0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check_val("rst_idle_no_writes", 32'(n0 - snap), 32'd0);
        check_val("rst_idle_busy", 32'(cap_busy0), 32'd0);
        base       = n0;
        ad0        = 8'd0;
        cap_start0 = 1'b1;
        wait_done0(1'b1, -1);
        verify_cap0("restart", base, 8'h80, 8'd1, 1'b0);

        // ---- test 5: DIV=5, constant input, forced trigger at 4th strobe ----
        @(posedge clk);
        #1;
        base       = n5;
        k0         = cyc;
        ad5        = 8'h10;
        lvl5       = 8'h80;
        edge5      = 1'b0;
        cap_start5 = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            cap_start5 = 1'b0;
            if (cap_done5) begin
                break;
            end
        end
        check_val("done5_reached", 32'(cap_done5), 32'd1);
        @(negedge clk);
        #1;
        bad_a = 0;
        bad_d = 0;
        bad_s = 0;
        for (int k = 0; k < 256; k++) begin
            if ((base + k) < 512) begin
                if (wa5[base + k] !== 8'(k)) begin
                    bad_a = bad_a + 1;
                end
                if (wd5[base + k] !== 8'h10) begin
                    bad_d = bad_d + 1;
                end
                if ((k > 0) && ((wc5[base + k] - wc5[base + k - 1]) != 6)) begin
                    bad_s = bad_s + 1;
                end
            end
        end
        check_val("forced_count", 32'(n5 - base), 32'd256);
        check_val("forced_first_latency", 32'(wc5[base] - k0), 32'd25);
        check_val("forced_addr_seq_errs", 32'(bad_a), 32'd0);
        check_val("forced_data_errs", 32'(bad_d), 32'd0);
        check_val("forced_spacing_errs", 32'(bad_s), 32'd0);
        check_val("forced_done_at_last", 32'(wdn5[base + 255]), 32'd1);
        check_val("forced_done_before_last", 32'(wdn5[base + 254]), 32'd0);
        check_val("forced_flag", 32'(forced5), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
